// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access-size codes,
// FSM state type and the wait-counter width helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  // Wait counter width; a 1-bit floor keeps degenerate timeouts legal.
  function automatic int cnt_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: request/ready handshake with byte-enabled writes.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  web;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, we, addr, web, wdata, input rdata, ready);
  modport slave  (input req, we, addr, web, wdata, output rdata, ready);
endinterface

// File: rtl/lsu_align.sv
// Combinational load/store alignment: store lane steering and byte
// enables, load lane extraction with sign/zero extension, misalign detect.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_write,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  web,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [31:0]        ld_shift;
  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;

  assign ld_shift = ld_word >> {addr_lo, 3'b000};
  assign ld_b     = ld_shift[7:0];
  assign ld_h     = ld_shift[15:0];

  // Store steering: replicate the operand across lanes, enable only the target bytes.
  always_comb begin
    web   = 4'b0000;
    wdata = st_data;
    case (funct3)
      F3_B: begin
        web   = 4'b0001 << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        web   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      F3_W:    web = 4'b1111;
      default: web = 4'b0000;
    endcase
    if (!is_write) web = 4'b0000;
  end

  // Misalign detect from the size field (funct3[1:0]); bytes never misalign.
  always_comb begin
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01:        misalign = addr_lo[0];
      2'b10, 2'b11: misalign = |addr_lo;
      default:      misalign = 1'b0;
    endcase
  end

  // Load extract: lane already shifted down, then extend per signedness.
  always_comb begin
    ld_data = ld_word;
    case (funct3)
      F3_B:    ld_data = 32'(ld_b);
      F3_H:    ld_data = 32'(ld_h);
      F3_BU:   ld_data = {24'b0, ld_shift[7:0]};
      F3_HU:   ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: drives the variable-latency data-memory port, stalls
// upstream during wait states, abandons accesses after TIMEOUT cycles and
// holds the MEM/WB pipeline register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXE_PCtoReg,
  input  logic [31:0] EXE_ALUout,
  input  logic [31:0] EXE_rs2data,
  input  logic [4:0]  EXE_rdaddr,
  input  logic [2:0]  EXE_Funct3,
  input  logic        EXE_rdsrc,
  input  logic        EXE_MemRead,
  input  logic        EXE_MemWrite,
  input  logic        EXE_MemtoReg,
  input  logic        EXE_RegWrite,
  mem_stage_if.master dm,
  output logic [31:0] Forward_Memrddata,
  output logic        MEM_stall,
  output logic [31:0] MEM_rddata,
  output logic [31:0] MEM_lddata,
  output logic [4:0]  MEM_rdaddr,
  output logic        MEM_MemtoReg,
  output logic        MEM_RegWrite,
  output logic        MEM_fault
);

  localparam int            CW       = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          access, is_write, misalign, aligned;
  logic          req, stall, complete, timed_out, cnt_clr, cnt_inc, fault_now;
  logic [3:0]    web;
  logic [31:0]   wdata, ld_data;

  assign access   = EXE_MemRead | EXE_MemWrite;
  assign is_write = EXE_MemWrite;
  assign aligned  = access & ~misalign;

  lsu_align u_lsu (
    .addr_lo  (EXE_ALUout[1:0]),
    .funct3   (EXE_Funct3),
    .is_write (is_write),
    .st_data  (EXE_rs2data),
    .ld_word  (dm.rdata),
    .web      (web),
    .wdata    (wdata),
    .ld_data  (ld_data),
    .misalign (misalign)
  );

  // Handshake FSM: request/stall decode; everything is gated off while in reset.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    stall     = 1'b0;
    complete  = 1'b0;
    timed_out = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (aligned) begin
            req = 1'b1;
            if (dm.ready) begin
              complete = 1'b1;
            end else begin
              stall     = 1'b1;
              cnt_clr   = 1'b1;
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          req = 1'b1;
          if (dm.ready) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else if (cnt == CNT_LAST) begin
            timed_out = 1'b1;
            state_nxt = IDLE;
          end else begin
            stall   = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign fault_now = (access & misalign) | timed_out;

  assign dm.req            = req;
  assign dm.we             = req & is_write;
  assign dm.addr           = {EXE_ALUout[31:2], 2'b00};
  assign dm.web            = web;
  assign dm.wdata          = wdata;
  assign MEM_stall         = stall;
  assign Forward_Memrddata = EXE_rdsrc ? EXE_PCtoReg : EXE_ALUout;

  // FSM state and wait-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
    end
  end

  // ---- MEM/WB boundary: bubble while stalled, faults kill the writeback ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEM_rddata   <= '0;
      MEM_lddata   <= '0;
      MEM_rdaddr   <= '0;
      MEM_MemtoReg <= 1'b0;
      MEM_RegWrite <= 1'b0;
      MEM_fault    <= 1'b0;
    end else if (stall) begin
      MEM_MemtoReg <= 1'b0;
      MEM_RegWrite <= 1'b0;
      MEM_fault    <= 1'b0;
    end else begin
      MEM_rddata   <= Forward_Memrddata;
      MEM_rdaddr   <= EXE_rdaddr;
      MEM_MemtoReg <= EXE_MemtoReg & ~fault_now;
      MEM_RegWrite <= EXE_RegWrite & ~fault_now;
      MEM_fault    <= fault_now;
      if (complete && !is_write) MEM_lddata <= ld_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized accesses checked
// against an arithmetic reference model of load/store alignment.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] EXE_PCtoReg, EXE_ALUout, EXE_rs2data;
  logic [4:0]  EXE_rdaddr;
  logic [2:0]  EXE_Funct3;
  logic        EXE_rdsrc, EXE_MemRead, EXE_MemWrite, EXE_MemtoReg, EXE_RegWrite;
  logic [31:0] Forward_Memrddata, MEM_rddata, MEM_lddata;
  logic        MEM_stall, MEM_MemtoReg, MEM_RegWrite, MEM_fault;
  logic [4:0]  MEM_rdaddr;

  mem_stage_if dm ();

  mem_stage #(.TIMEOUT(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .EXE_PCtoReg       (EXE_PCtoReg),
    .EXE_ALUout        (EXE_ALUout),
    .EXE_rs2data       (EXE_rs2data),
    .EXE_rdaddr        (EXE_rdaddr),
    .EXE_Funct3        (EXE_Funct3),
    .EXE_rdsrc         (EXE_rdsrc),
    .EXE_MemRead       (EXE_MemRead),
    .EXE_MemWrite      (EXE_MemWrite),
    .EXE_MemtoReg      (EXE_MemtoReg),
    .EXE_RegWrite      (EXE_RegWrite),
    .dm                (dm),
    .Forward_Memrddata (Forward_Memrddata),
    .MEM_stall         (MEM_stall),
    .MEM_rddata        (MEM_rddata),
    .MEM_lddata        (MEM_lddata),
    .MEM_rdaddr        (MEM_rdaddr),
    .MEM_MemtoReg      (MEM_MemtoReg),
    .MEM_RegWrite      (MEM_RegWrite),
    .MEM_fault         (MEM_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rw_pulses = 0;

  always @(negedge clk) if (MEM_RegWrite === 1'b1) rw_pulses++;

  // Observations from the most recent access.
  int          r_stalls;
  logic        r_req, r_we, r_stable, r_done;
  logic [3:0]  r_web;
  logic [31:0] r_wdata, r_addr;

  // Reference: extracted load value from plain lane arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v, mask;
    int nbytes;
    if (f3 == F3_W) return word;
    nbytes = f3[0] ? 2 : 1;
    mask = (nbytes == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (word >> (8 * (addr % 4))) & mask;
    if (!f3[2] && (((v >> (8 * nbytes - 1)) & 32'd1) == 32'd1)) v = v | ~mask;
    return v;
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  task automatic set_exe(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [4:0] rd, input logic rdsrc,
                         input logic mr, input logic mw, input logic m2r, input logic rw);
    EXE_Funct3 = f3; EXE_ALUout = addr; EXE_rs2data = rs2; EXE_PCtoReg = pc;
    EXE_rdaddr = rd; EXE_rdsrc = rdsrc; EXE_MemRead = mr; EXE_MemWrite = mw;
    EXE_MemtoReg = m2r; EXE_RegWrite = rw;
  endtask

  task automatic clear_exe();
    EXE_MemRead = 1'b0; EXE_MemWrite = 1'b0; EXE_MemtoReg = 1'b0; EXE_RegWrite = 1'b0;
    EXE_rdsrc = 1'b0;
  endtask

  task automatic idle_cycle();
    clear_exe();
    @(posedge clk); #1;
  endtask

  // Presents the already-driven access until the stage stops stalling
  // (bounded); memory answers after wait_n wait cycles.
  task automatic run_access(input int wait_n, input logic [31:0] rdata);
    logic stall_now;
    r_stalls = 0; r_stable = 1'b1; r_done = 1'b0;
    dm.ready = (wait_n == 0);
    dm.rdata = (wait_n == 0) ? rdata : $urandom;
    #1;
    r_req = dm.req; r_we = dm.we; r_web = dm.web; r_wdata = dm.wdata; r_addr = dm.addr;
    for (int c = 0; c < 40; c++) begin
      dm.ready = (c == wait_n);
      dm.rdata = (c == wait_n) ? rdata : $urandom;
      #1;
      if (dm.addr !== r_addr) r_stable = 1'b0;
      stall_now = MEM_stall;
      if (stall_now) r_stalls++;
      @(posedge clk); #1;
      if (!stall_now) begin r_done = 1'b1; break; end
    end
    dm.ready = 1'b0;
    clear_exe();
  endtask

  task automatic test_reset();
    #12;
    total++; if (dm.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", dm.req); end
    total++; if (MEM_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", MEM_stall); end
    total++; if ({MEM_rddata, MEM_lddata, MEM_rdaddr, MEM_MemtoReg, MEM_RegWrite, MEM_fault} !== '0) begin
      bad++; $display("FAIL reset_regs got=%h/%h/%h/%b/%b/%b exp=0", MEM_rddata, MEM_lddata,
                      MEM_rdaddr, MEM_MemtoReg, MEM_RegWrite, MEM_fault);
    end
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_store_sw();
    idle_cycle();
    set_exe(F3_W, 32'h0000_1004, 32'hDEAD_BEEF, 32'h40, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_access(0, 32'h0);
    total++; if (r_web !== 4'b1111) begin bad++; $display("FAIL sw_web got=%b exp=1111", r_web); end
    total++; if (r_addr !== 32'h1004) begin bad++; $display("FAIL sw_addr got=%h exp=00001004", r_addr); end
    total++; if (r_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", r_wdata); end
    total++; if ({r_req, r_we} !== 2'b11) begin bad++; $display("FAIL sw_req_we got=%b%b exp=11", r_req, r_we); end
    total++; if (r_stalls != 0) begin bad++; $display("FAIL sw_stall got=%0d exp=0", r_stalls); end
    total++; if (MEM_RegWrite !== 1'b0) begin bad++; $display("FAIL sw_regwrite got=%b exp=0", MEM_RegWrite); end
    total++; if (MEM_rddata !== 32'h1004) begin bad++; $display("FAIL sw_rddata got=%h exp=00001004", MEM_rddata); end
  endtask

  task automatic test_store_sb();
    idle_cycle();
    set_exe(F3_B, 32'h0000_1003, 32'h0000_00A5, 32'h44, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_access(0, 32'h0);
    total++; if (r_web !== 4'b1000) begin bad++; $display("FAIL sb_web got=%b exp=1000", r_web); end
    total++; if (r_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", r_wdata); end
    total++; if (r_addr !== 32'h1000) begin bad++; $display("FAIL sb_addr got=%h exp=00001000", r_addr); end
  endtask

  task automatic test_load_byte();
    idle_cycle();
    set_exe(F3_B, 32'h0000_2002, 32'h0, 32'h48, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_access(0, 32'h12F0_3456);
    total++; if (MEM_lddata !== 32'hFFFF_FFF0) begin bad++; $display("FAIL lb_data got=%h exp=fffffff0", MEM_lddata); end
    total++; if ({MEM_RegWrite, MEM_MemtoReg} !== 2'b11) begin bad++; $display("FAIL lb_ctrl got=%b%b exp=11", MEM_RegWrite, MEM_MemtoReg); end
    total++; if (MEM_rdaddr !== 5'd7) begin bad++; $display("FAIL lb_rd got=%0d exp=7", MEM_rdaddr); end
    total++; if (r_web !== 4'b0000) begin bad++; $display("FAIL lb_web got=%b exp=0000", r_web); end
    set_exe(F3_BU, 32'h0000_2002, 32'h0, 32'h4C, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_access(0, 32'h12F0_3456);
    total++; if (MEM_lddata !== 32'h0000_00F0) begin bad++; $display("FAIL lbu_data got=%h exp=000000f0", MEM_lddata); end
  endtask

  task automatic test_load_wait();
    idle_cycle();
    rw_pulses = 0;
    set_exe(F3_H, 32'h0000_3002, 32'h0, 32'h50, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_access(3, 32'h8001_5A5A);
    total++; if (r_stalls != 3) begin bad++; $display("FAIL lh_wait_stall got=%0d exp=3", r_stalls); end
    total++; if (r_stable !== 1'b1) begin bad++; $display("FAIL lh_wait_addr_stable got=%b exp=1", r_stable); end
    total++; if (MEM_lddata !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_wait_data got=%h exp=ffff8001", MEM_lddata); end
    total++; if (MEM_RegWrite !== 1'b1) begin bad++; $display("FAIL lh_wait_regwrite got=%b exp=1", MEM_RegWrite); end
    idle_cycle();
    total++; if (rw_pulses != 1) begin bad++; $display("FAIL lh_wait_pulses got=%0d exp=1", rw_pulses); end
  endtask

  task automatic test_misalign();
    idle_cycle();
    set_exe(F3_W, 32'h0000_4001, 32'h0, 32'h54, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_access(0, 32'h1234_5678);
    total++; if (r_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%b exp=0", r_req); end
    total++; if (r_stalls != 0) begin bad++; $display("FAIL mis_stall got=%0d exp=0", r_stalls); end
    total++; if ({MEM_fault, MEM_RegWrite} !== 2'b10) begin bad++; $display("FAIL mis_fault_rw got=%b%b exp=10", MEM_fault, MEM_RegWrite); end
    idle_cycle();
    total++; if (MEM_fault !== 1'b0) begin bad++; $display("FAIL mis_fault_len got=%b exp=0", MEM_fault); end
  endtask

  task automatic test_timeout();
    idle_cycle();
    set_exe(F3_W, 32'h0000_4000, 32'h0, 32'h58, 5'd11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_access(1000, 32'h0);
    total++; if (r_done !== 1'b1) begin bad++; $display("FAIL to_done got=%b exp=1", r_done); end
    total++; if (r_stalls != 16) begin bad++; $display("FAIL to_stall got=%0d exp=16", r_stalls); end
    total++; if ({MEM_fault, MEM_RegWrite} !== 2'b10) begin bad++; $display("FAIL to_fault_rw got=%b%b exp=10", MEM_fault, MEM_RegWrite); end
    idle_cycle();
    total++; if (MEM_fault !== 1'b0) begin bad++; $display("FAIL to_fault_len got=%b exp=0", MEM_fault); end
  endtask

  task automatic test_reset_mid_wait();
    idle_cycle();
    set_exe(F3_W, 32'h0000_5000, 32'h0, 32'h5C, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    dm.ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if ({dm.req, MEM_stall} !== 2'b11) begin bad++; $display("FAIL rstw_pre got=%b%b exp=11", dm.req, MEM_stall); end
    rst = 1'b0;
    #1;
    total++; if (dm.req !== 1'b0) begin bad++; $display("FAIL rstw_req got=%b exp=0", dm.req); end
    total++; if (MEM_stall !== 1'b0) begin bad++; $display("FAIL rstw_stall got=%b exp=0", MEM_stall); end
    total++; if (MEM_rddata !== 32'h0) begin bad++; $display("FAIL rstw_rddata got=%h exp=0", MEM_rddata); end
    @(posedge clk); #1;
    rst = 1'b1;
    set_exe(F3_W, 32'h0000_5008, 32'h0, 32'h60, 5'd13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_access(0, 32'hCAFE_F00D);
    total++; if (r_stalls != 0) begin bad++; $display("FAIL rstw_lw_stall got=%0d exp=0", r_stalls); end
    total++; if (MEM_lddata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rstw_lw_data got=%h exp=cafef00d", MEM_lddata); end
    total++; if ({MEM_RegWrite, MEM_rdaddr} !== {1'b1, 5'd13}) begin bad++; $display("FAIL rstw_lw_ctrl got=%b/%0d exp=1/13", MEM_RegWrite, MEM_rdaddr); end
  endtask

  task automatic test_random();
    logic [2:0]  ld_codes [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    logic [2:0]  f3;
    logic [31:0] addr, rs2, pc, rdata, exp_wdata, exp_rd, mask, rep;
    logic [4:0]  rd;
    logic        mw, mr, rw, rdsrc, mis;
    logic [3:0]  exp_web;
    int          wait_n, sz;
    for (int i = 0; i < 60; i++) begin
      clear_exe();
      dm.ready = $urandom_range(0, 1);
      @(posedge clk); #1;
      total++; if ({MEM_RegWrite, MEM_fault} !== 2'b00) begin bad++; $display("FAIL rnd_idle_ready it=%0d got=%b%b exp=00", i, MEM_RegWrite, MEM_fault); end
      mw = $urandom_range(0, 1);
      mr = mw ? ($urandom_range(0, 3) == 0) : 1'b1;
      f3 = mw ? ld_codes[$urandom_range(0, 2)] : ld_codes[$urandom_range(0, 4)];
      addr = $urandom; rs2 = $urandom; pc = $urandom; rdata = $urandom;
      rd = 5'($urandom_range(1, 31)); rdsrc = $urandom_range(0, 1);
      rw = mw ? 1'b0 : 1'($urandom_range(0, 1));
      wait_n = $urandom_range(0, 3);
      sz = ref_size(f3);
      mis = (addr % sz) != 0;
      set_exe(f3, addr, rs2, pc, rd, rdsrc, mr, mw, !mw, rw);
      run_access(wait_n, rdata);
      exp_rd = rdsrc ? pc : addr;
      total++; if (r_stalls != (mis ? 0 : wait_n)) begin bad++; $display("FAIL rnd_stall it=%0d got=%0d exp=%0d", i, r_stalls, mis ? 0 : wait_n); end
      total++; if (r_req !== !mis) begin bad++; $display("FAIL rnd_req it=%0d got=%b exp=%b", i, r_req, !mis); end
      total++; if ({MEM_fault, MEM_RegWrite} !== {mis, rw & !mis}) begin bad++; $display("FAIL rnd_fault_rw it=%0d got=%b%b exp=%b%b", i, MEM_fault, MEM_RegWrite, mis, rw & !mis); end
      total++; if (MEM_rddata !== exp_rd) begin bad++; $display("FAIL rnd_rddata it=%0d got=%h exp=%h", i, MEM_rddata, exp_rd); end
      if (!mis && mw) begin
        exp_web = 4'(((1 << sz) - 1) << (addr % 4));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
        rep  = (sz == 1) ? 32'h0101_0101 : (sz == 2) ? 32'h0001_0001 : 32'h1;
        exp_wdata = (rs2 & mask) * rep;
        total++; if (r_web !== exp_web) begin bad++; $display("FAIL rnd_web it=%0d got=%b exp=%b", i, r_web, exp_web); end
        total++; if (r_wdata !== exp_wdata) begin bad++; $display("FAIL rnd_wdata it=%0d got=%h exp=%h", i, r_wdata, exp_wdata); end
        total++; if (r_we !== 1'b1) begin bad++; $display("FAIL rnd_we it=%0d got=%b exp=1", i, r_we); end
      end else if (!mis) begin
        total++; if (r_web !== 4'b0000) begin bad++; $display("FAIL rnd_ld_web it=%0d got=%b exp=0000", i, r_web); end
        total++; if (MEM_lddata !== ref_load(f3, addr, rdata)) begin bad++; $display("FAIL rnd_lddata it=%0d f3=%0d a=%h w=%h got=%h exp=%h", i, f3, addr, rdata, MEM_lddata, ref_load(f3, addr, rdata)); end
      end
    end
  endtask

  initial begin
    clear_exe();
    EXE_Funct3 = 3'b0; EXE_ALUout = '0; EXE_rs2data = '0; EXE_PCtoReg = '0; EXE_rdaddr = '0;
    dm.ready = 1'b0; dm.rdata = '0;
    test_reset();
    test_store_sw();
    test_store_sb();
    test_load_byte();
    test_load_wait();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline, directly downstream of EXE, consuming its registered EXE/MEM outputs. Drives a variable-latency data-memory port with a req/ready handshake. Performs store byte-lane steering and load alignment and sign extension. Stalls the pipeline during wait states and holds the MEM/WB pipeline register.

## Interface
- `TIMEOUT`, 16: maximum cycles spent in WAIT before the access is abandoned.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: asynchronous, active-low reset (asserted at 0).
- `EXE_PCtoReg, EXE_ALUout, EXE_rs2data  in  32 each`: link value, address/result, store data.
- `EXE_rdaddr  in  5`; `EXE_Funct3  in  3`: destination register and access size/sign.
- `EXE_rdsrc, EXE_MemRead, EXE_MemWrite, EXE_MemtoReg, EXE_RegWrite  in  1 each`: control bits.
- `DM_req  out  1`; `DM_we  out  1`: request valid and write qualifier.
- `DM_addr  out  32`: `{EXE_ALUout[31:2],2'b00}`.
- `DM_web  out  4`: active-high byte enables.
- `DM_wdata  out  32`: lane-steered store data.
- `DM_rdata  in  32`; `DM_ready  in  1`: read data and completion, sampled on the same edge.
- `Forward_Memrddata  out  32`: combinational; `EXE_rdsrc ? EXE_PCtoReg : EXE_ALUout`.
- `MEM_stall  out  1`: hold PC/IF/ID/EXE registers.
- `MEM_rddata, MEM_lddata  out  32`: registered non-load result and aligned load data.
- `MEM_rdaddr  out  5`; `MEM_MemtoReg, MEM_RegWrite  out  1`: registered WB controls.
- `MEM_fault  out  1`: registered one-cycle pulse for a misaligned or timed-out access.

## Operation
- An access is `EXE_MemRead | EXE_MemWrite`. If both are set, it is treated as a write.
- Misaligned accesses:
  - Halfword: `addr[0]=1`.
  - Word: `addr[1:0]!=0`.
  - Required response: no `DM_req`, `MEM_fault` pulses, `MEM_RegWrite<=0`, no stall.
- Store enables:
  - SB (000): `web = 4'b0001<<addr[1:0]`, wdata = byte replicated ×4.
  - SH (001): `web = addr[1] ? 4'b1100 : 4'b0011`, wdata = half replicated ×2.
  - SW (010): `web = 4'b1111`.
  - Loads: `web = 0`.
- Load extract (`addr[1:0]` selects the lane):
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) passes the word through.
- FSM states:
  - IDLE: on an aligned access, `DM_req=1` combinationally.
    - If `DM_ready=1`: complete this cycle, stay IDLE, no stall.
    - Otherwise: go to WAIT, `MEM_stall=1`, counter cleared.
  - WAIT: `DM_req=1`, with addr/web/wdata stable because upstream is held by the stall. The counter increments each cycle.
    - On `DM_ready`: complete, go to IDLE, `MEM_stall=0` in that same cycle.
    - When the counter reaches `TIMEOUT-1` without ready: abandon the access, `MEM_fault`, `MEM_RegWrite<=0`, go to IDLE.
- MEM/WB register update rules:
  - Every cycle with `MEM_stall=0`: `MEM_rddata<=Forward_Memrddata`, `MEM_lddata<=extract(DM_rdata)`, and the control bits pass through.
  - Every cycle with `MEM_stall=1`: bubble, `MEM_RegWrite<=0` and `MEM_MemtoReg<=0`; data fields hold.
- `DM_rdata` is used only on the completing edge.

## Timing
- Zero-wait load: WB data appears on MEM outputs 1 cycle after the EXE/MEM register presents the access.
- N-wait load: `MEM_stall` is high for exactly N cycles and the result appears at N+1.
- `MEM_stall` is combinational from the FSM state and `DM_ready`, and is never high in IDLE without an access.
- Reset (`rst=0`, asynchronous):
  - FSM returns to IDLE, counter cleared.
  - `DM_req` drops to 0 immediately, including mid-WAIT.
  - All registered outputs become 0.
- `MEM_fault` is high for exactly one cycle per faulting access.
- `DM_ready` asserted while no request is pending is ignored.

## Structure
- Package `mem_pkg` holds:
  - funct3 constants: `F3_B=3'b000`, `F3_H=3'b001`, `F3_W=3'b010`, `F3_BU=3'b100`, `F3_HU=3'b101`.
  - State enum `mem_state_t {IDLE, WAIT}`.
  - Counter width `$clog2(TIMEOUT)`.
- Sub-module `lsu_align` is purely combinational: store lane steering and byte enables, load extract, misalign detect.
- `mem_stage` keeps the FSM, the counter and the MEM/WB register.

## Test plan
- SW to `0x1004`, data `0xDEADBEEF`, ready same cycle:
  - Required: `DM_web=4'b1111`, `DM_addr=0x1004`, no stall, `MEM_RegWrite=0`.
- SB to `0x1003`, `rs2=0x000000A5`:
  - Required: `DM_web=4'b1000`, `DM_wdata=0xA5A5A5A5`.
- LB from `0x2002` with rdata `0x12F03456`, and LBU at the same address:
  - Required: LB gives `MEM_lddata=0xFFFFFFF0`; LBU gives `0x000000F0`.
- LH from `0x3002` with ready delayed 3 cycles and rdata `0x8001xxxx`:
  - Required: `MEM_stall` high for 3 cycles, `DM_addr` stable, `MEM_lddata=0xFFFF8001`, exactly one `MEM_RegWrite` pulse.
- LW from `0x4001`:
  - Required: no `DM_req`, `MEM_fault` for one cycle, `MEM_RegWrite=0`.
  - Separately: LW with ready never asserted gives a `TIMEOUT` (16) cycle stall, then `MEM_fault`.
- `rst` pulled low during cycle 2 of WAIT:
  - Required: `DM_req=0` and `MEM_stall=0` immediately.
  - After release, a new zero-wait LW completes normally.
